// File: rtl/cpu_state_sequencer_if.sv
// Sequencer <-> datapath/memory control bundle: decode flags and memory
// handshake in, cpu state, strobes and status out.
interface cpu_state_sequencer_if;
    logic        waitrequest;
    logic        pc_zero;
    logic        op_load;
    logic        op_store;
    logic        op_muldiv;
    logic [2:0]  state;
    logic        read;
    logic        write;
    logic        pc_write;
    logic        muldiv_busy;
    logic        active;
    logic [31:0] instr_count;

    modport master (
        input  waitrequest, pc_zero, op_load, op_store, op_muldiv,
        output state, read, write, pc_write, muldiv_busy, active, instr_count
    );

    modport slave (
        output waitrequest, pc_zero, op_load, op_store, op_muldiv,
        input  state, read, write, pc_write, muldiv_busy, active, instr_count
    );
endinterface

// File: rtl/cpu_state_sequencer.sv
// Multi-cycle MIPS control sequencer: fetch/decode/execute states, memory
// strobes with waitrequest, mult/div stall timer, halt on fetch from PC 0.
//
//   state  | meaning
//   FETCH  | read instruction at PC, hold on waitrequest, halt if PC == 0
//   LOAD   | IR captures readdata
//   EXEC1  | decode; ALU ops retire here
//   EXEC2  | memory access (holds on waitrequest) or mult/div stall
//   EXEC3  | load writeback
//   HALTED | absorbing, only reset leaves it
module cpu_state_sequencer #(
    parameter int MULDIV_CYCLES = 34
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_state_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        LOAD   = 3'd1,
        EXEC1  = 3'd2,
        EXEC2  = 3'd3,
        EXEC3  = 3'd4,
        HALTED = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  stall_q, stall_d;
    logic [31:0] count_q, count_d;
    logic        mem_op;
    logic        retire;

    assign mem_op = bus.op_load | bus.op_store;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            stall_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        case (state_q)
            FETCH: begin
                if (bus.pc_zero)
                    state_d = HALTED;
                else if (!bus.waitrequest)
                    state_d = LOAD;
            end
            LOAD:  state_d = EXEC1;
            EXEC1: begin
                // a memory op outranks a simultaneous (illegal) muldiv decode
                if (mem_op) begin
                    state_d = EXEC2;
                end else if (bus.op_muldiv) begin
                    state_d = EXEC2;
                    stall_d = 6'(MULDIV_CYCLES - 1);
                end else begin
                    state_d = FETCH;
                end
            end
            EXEC2: begin
                if (mem_op) begin
                    if (!bus.waitrequest)
                        state_d = bus.op_load ? EXEC3 : FETCH;
                end else if (stall_q != 6'd0) begin
                    stall_d = stall_q - 6'd1;
                end else begin
                    state_d = FETCH;
                end
            end
            EXEC3:   state_d = FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase

        retire  = (state_q != FETCH) && (state_d == FETCH);
        count_d = retire ? count_q + 32'd1 : count_q;
    end

    always_comb begin
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.pc_write    = 1'b0;
        bus.muldiv_busy = 1'b0;
        bus.active      = (state_q != HALTED);
        bus.state       = state_q;
        bus.instr_count = count_q;
        // strobes are gated by reset so an interrupted transfer drops at once
        if (reset) begin
            bus.read        = ((state_q == FETCH) && !bus.pc_zero) ||
                              ((state_q == EXEC2) && bus.op_load);
            bus.write       = (state_q == EXEC2) && bus.op_store && !bus.op_load;
            bus.pc_write    = retire;
            bus.muldiv_busy = (stall_q != 6'd0);
        end
    end
endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Self-checking bench for cpu_state_sequencer: table of per-cycle vectors
// checked through an expectation queue, plus hand-written reset sequences.
module tb_cpu_state_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;

    cpu_state_sequencer_if bus();

    cpu_state_sequencer #(.MULDIV_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        bit       wr, pz, ld, st, md;
        bit [2:0] s;
        bit       rd, wt, pcw, busy, act;
    } vec_t;

    typedef struct {
        string       name;
        bit [2:0]    s;
        bit          rd, wt, pcw, busy, act;
        logic [31:0] cnt;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_err = 0;
    int          n_checks = 0;
    logic [31:0] exp_cnt = 0;

    task automatic add(string n, bit wr, bit pz, bit ld, bit st, bit md,
                       bit [2:0] s, bit rd, bit wt, bit pcw, bit busy, bit act);
        vec_t v;
        v.name = n; v.wr = wr; v.pz = pz; v.ld = ld; v.st = st; v.md = md;
        v.s = s; v.rd = rd; v.wt = wt; v.pcw = pcw; v.busy = busy; v.act = act;
        vecs.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit wr, bit pz, bit ld, bit st, bit md);
        bus.waitrequest = wr;
        bus.pc_zero     = pz;
        bus.op_load     = ld;
        bus.op_store    = st;
        bus.op_muldiv   = md;
    endtask

    // called at a falling edge; leaves at the next falling edge
    task automatic apply(int i);
        exp_t e;
        drive(vecs[i].wr, vecs[i].pz, vecs[i].ld, vecs[i].st, vecs[i].md);
        e.name = vecs[i].name; e.s = vecs[i].s; e.rd = vecs[i].rd;
        e.wt = vecs[i].wt; e.pcw = vecs[i].pcw; e.busy = vecs[i].busy;
        e.act = vecs[i].act; e.cnt = exp_cnt;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk({e.name, ".state"}, 32'(bus.state), 32'(e.s));
        chk({e.name, ".read"}, 32'(bus.read), 32'(e.rd));
        chk({e.name, ".write"}, 32'(bus.write), 32'(e.wt));
        chk({e.name, ".pc_write"}, 32'(bus.pc_write), 32'(e.pcw));
        chk({e.name, ".muldiv_busy"}, 32'(bus.muldiv_busy), 32'(e.busy));
        chk({e.name, ".active"}, 32'(bus.active), 32'(e.act));
        chk({e.name, ".instr_count"}, bus.instr_count, e.cnt);
        if (e.pcw) exp_cnt++;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1_end, s2_end, s3_end;
        //   name       wr pz ld st md  st rd wt pcw busy act
        add("alu_f",     0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        add("alu_l",     0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1);
        add("alu_e1",    0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 1);
        add("fw_f0",     1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        add("fw_f1",     1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        add("fw_f2",     1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        add("fw_f3",     0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        add("fw_l",      0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1);
        add("fw_e1",     0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 1);
        add("lw_f",      0, 0, 1, 0, 0,  0, 1, 0, 0, 0, 1);
        add("lw_l",      0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 1);
        add("lw_e1",     0, 0, 1, 0, 0,  2, 0, 0, 0, 0, 1);
        add("lw_e2a",    1, 0, 1, 0, 0,  3, 1, 0, 0, 0, 1);
        add("lw_e2b",    1, 0, 1, 0, 0,  3, 1, 0, 0, 0, 1);
        add("lw_e2c",    0, 0, 1, 0, 0,  3, 1, 0, 0, 0, 1);
        add("lw_e3",     0, 0, 1, 0, 0,  4, 0, 0, 1, 0, 1);
        add("sw_f",      0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1);
        add("sw_l",      0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1);
        add("sw_e1",     0, 0, 0, 1, 0,  2, 0, 0, 0, 0, 1);
        add("sw_e2a",    1, 0, 0, 1, 0,  3, 0, 1, 0, 0, 1);
        add("sw_e2b",    0, 0, 0, 1, 0,  3, 0, 1, 1, 0, 1);
        add("mul_f",     0, 0, 0, 0, 1,  0, 1, 0, 0, 0, 1);
        add("mul_l",     0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1);
        add("mul_e1",    0, 0, 0, 0, 1,  2, 0, 0, 0, 0, 1);
        add("mul_e2a",   1, 0, 0, 0, 1,  3, 0, 0, 0, 1, 1);
        add("mul_e2b",   1, 0, 0, 0, 1,  3, 0, 0, 0, 1, 1);
        add("mul_e2c",   1, 0, 0, 0, 1,  3, 0, 0, 0, 1, 1);
        add("mul_e2d",   1, 0, 0, 0, 1,  3, 0, 0, 1, 0, 1);
        add("ill_f",     0, 0, 1, 0, 1,  0, 1, 0, 0, 0, 1);
        add("ill_l",     0, 0, 1, 0, 1,  1, 0, 0, 0, 0, 1);
        add("ill_e1",    0, 0, 1, 0, 1,  2, 0, 0, 0, 0, 1);
        add("ill_e2",    0, 0, 1, 0, 1,  3, 1, 0, 0, 0, 1);
        add("ill_e3",    0, 0, 1, 0, 1,  4, 0, 0, 1, 0, 1);
        add("halt_f",    0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        add("halt_a",    0, 1, 0, 0, 0,  5, 0, 0, 0, 0, 0);
        add("halt_b",    0, 0, 1, 0, 0,  5, 0, 0, 0, 0, 0);
        add("halt_c",    0, 0, 0, 1, 0,  5, 0, 0, 0, 0, 0);
        s1_end = vecs.size();
        add("rst_sw_f",  0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 1);
        add("rst_sw_l",  0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1);
        add("rst_sw_e1", 1, 0, 0, 1, 0,  2, 0, 0, 0, 0, 1);
        add("rst_sw_e2", 1, 0, 0, 1, 0,  3, 0, 1, 0, 0, 1);
        s2_end = vecs.size();
        add("post_f",    0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1);
        add("post_l",    0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1);
        add("post_e1",   0, 0, 0, 0, 0,  2, 0, 0, 1, 0, 1);
        s3_end = vecs.size();

        // reset state: strobes gated even though FETCH with pc_zero=0
        drive(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst.state", 32'(bus.state), 32'd0);
        chk("rst.read", 32'(bus.read), 32'd0);
        chk("rst.write", 32'(bus.write), 32'd0);
        chk("rst.pc_write", 32'(bus.pc_write), 32'd0);
        chk("rst.muldiv_busy", 32'(bus.muldiv_busy), 32'd0);
        chk("rst.active", 32'(bus.active), 32'd1);
        chk("rst.instr_count", bus.instr_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < s1_end; i++) apply(i);

        // asynchronous reset out of HALTED with a nonzero count
        #2;
        drive(1, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("halt_rst.state", 32'(bus.state), 32'd0);
        chk("halt_rst.active", 32'(bus.active), 32'd1);
        chk("halt_rst.instr_count", bus.instr_count, 32'd0);
        chk("halt_rst.read", 32'(bus.read), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;

        for (int i = s1_end; i < s2_end; i++) apply(i);

        // store stalled in EXEC2: reset mid-transfer drops write immediately
        #1;
        chk("midxfer.write_before", 32'(bus.write), 32'd1);
        chk("midxfer.state_before", 32'(bus.state), 32'd3);
        reset = 1'b0;
        #1;
        chk("midxfer.write", 32'(bus.write), 32'd0);
        chk("midxfer.read", 32'(bus.read), 32'd0);
        chk("midxfer.state", 32'(bus.state), 32'd0);
        chk("midxfer.pc_write", 32'(bus.pc_write), 32'd0);
        chk("midxfer.instr_count", bus.instr_count, 32'd0);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 0;

        for (int i = s2_end; i < s3_end; i++) apply(i);
        #1;
        chk("post.instr_count", bus.instr_count, 32'd1);
        chk("post.state", 32'(bus.state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_state_sequencer.md
Name: cpu_state_sequencer

Overview:
Multi-cycle control sequencer for the MIPS CPU. It generates the 3-bit cpu state consumed by the instruction register, register file, PC and ALU blocks. It drives the Avalon-style memory read/write strobes and honours waitrequest. It also stalls EXEC2 for multiply/divide and detects the halt condition (fetch from address 0).

Parameters:
MULDIV_CYCLES, 34, number of EXEC2 cycles held for mult/multu/div/divu (range 1..63).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
waitrequest  in  1  memory stall; a transfer completes on a clk edge where read|write=1 and waitrequest=0.
pc_zero  in  1  current PC == 0x00000000.
op_load  in  1  decoded IR is lw/lb/lbu/lh/lhu/lwl/lwr; valid from EXEC1 onward.
op_store  in  1  decoded IR is sw/sb/sh.
op_muldiv  in  1  decoded IR is mult/multu/div/divu.
state  out  3  FETCH=0, LOAD=1, EXEC1=2, EXEC2=3, EXEC3=4, HALTED=5.
read  out  1  memory read strobe.
write  out  1  memory write strobe.
pc_write  out  1  one-cycle PC update enable.
muldiv_busy  out  1  high while the muldiv stall counter is running.
active  out  1  CPU running; low only in HALTED.
instr_count  out  32  retired-instruction counter.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, stall counter=0, instr_count=0.
  - read, write, pc_write and muldiv_busy forced 0 while reset is low. active=1.
- Output decode (combinational from registered state):
  - read = (FETCH & !pc_zero) | (EXEC2 & op_load).
  - write = EXEC2 & op_store.
  - pc_write = 1 on the final cycle of each instruction (the cycle whose edge transitions to FETCH).
  - active = (state != HALTED).
- FETCH:
  - pc_zero=1 -> HALTED next edge; no read is issued.
  - Otherwise hold while waitrequest=1; on waitrequest=0 -> LOAD.
- LOAD: IR captures memory readdata on this cycle's edge; unconditional -> EXEC1.
- EXEC1:
  - op_load|op_store|op_muldiv -> EXEC2.
  - Else -> FETCH, with pc_write=1 and instr_count+1.
- EXEC2, memory op (op_load or op_store):
  - Hold while waitrequest=1.
  - On waitrequest=0: load -> EXEC3; store -> FETCH (pc_write=1, count+1).
- EXEC2, muldiv:
  - Stall counter loads MULDIV_CYCLES-1 on EXEC1->EXEC2 entry; muldiv_busy=1 while counter!=0.
  - Counter decrements each cycle; at 0 -> FETCH (pc_write=1, count+1).
  - Total EXEC2 residency is exactly MULDIV_CYCLES cycles.
- EXEC3 (load writeback): one cycle -> FETCH, pc_write=1, count+1.
- HALTED: absorbing state. read=write=pc_write=0. Only reset leaves it.
- Priority: if op_muldiv and a memory op are both asserted (illegal decode), the memory op wins.
- instr_count wraps 0xFFFFFFFF -> 0; it does not increment in HALTED.
- Reset asserted mid-transfer (waitrequest high): strobes drop immediately, state returns to FETCH. No partial write is retried.
- read and write are never high in the same cycle.

Test Plan:
- ALU instruction, waitrequest=0: states 0,1,2,0. read=1 in cycle 0 only. pc_write=1 in the EXEC1 cycle. instr_count 0->1.
- FETCH with waitrequest=1 for 3 cycles: state stays 0 for 4 cycles with read held high. LOAD entered on the 5th cycle.
- lw with waitrequest=1 for 2 cycles in EXEC2: sequence 0,1,2,3,3,3,4,0. read high in FETCH and all EXEC2 cycles. write=0 throughout.
- sw: state 3 with write=1 and read=0; returns to FETCH after waitrequest=0. instr_count increments once.
- mult with MULDIV_CYCLES=4: EXEC2 lasts exactly 4 cycles with muldiv_busy=1,1,1,0. Then FETCH.
- pc_zero=1 in FETCH: next state 5, active=0, read=0 indefinitely. Asynchronous reset pulse -> state 0, active=1, instr_count=0 without waiting for clk.
